// File: rtl/ether_payload_feeder.sv
// ether_payload_feeder
//
// Store-and-forward payload source for the RMII transmit framer. It collects one frame of
// application bytes into a single-port byte RAM and then requests transmission with a
// one-cycle preamble_signal pulse. When the framer answers with give_data, it streams the
// payload as contiguous LSB-first dibits, zero-padded to MIN_PAYLOAD bytes. The data phase
// ends with a one-cycle data_complete pulse.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous reset, active-low
//   s_valid/s_data/s_last/s_ready
//                   byte stream from the application (transfer on s_valid & s_ready)
//   preamble_signal one-cycle request for frame transmission
//   give_data       one-cycle pulse from the framer: start the payload
//   axiov/axiod     payload dibit valid / dibit
//   data_complete   one-cycle pulse on the cycle after the last dibit
//   frame_err       one-cycle pulse (with preamble_signal) when the frame was truncated
//
// All outputs are registered.

module ether_payload_feeder #(
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       preamble_signal,
  input  logic       give_data,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       data_complete,
  output logic       frame_err
);

  localparam int unsigned CntW  = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned AddrW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_PAYLOAD);
  localparam logic [CntW-1:0] MinCnt = CntW'(MIN_PAYLOAD);

  typedef enum logic [2:0] {
    StCollect,
    StReq,
    StWait,
    StStream,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  // Index of the next byte to load into cur_q; also the RAM read address while streaming.
  logic [CntW-1:0] rd_idx_q, rd_idx_d;
  // Index of the next dibit of cur_q to send; 0 means a new byte is due.
  logic [1:0]      ph_q, ph_d;
  logic [7:0]      cur_q, cur_d;
  logic            ovf_q, ovf_d;
  logic            s_ready_q, s_ready_d;
  logic            preamble_q, preamble_d;
  logic            frame_err_q, frame_err_d;
  logic            axiov_q, axiov_d;
  logic [1:0]      axiod_q, axiod_d;
  logic            done_q, done_d;

  logic [7:0]      mem [MAX_PAYLOAD];
  logic [7:0]      ram_rdata;
  logic [CntW-1:0] ram_addr;
  logic            ram_we;

  logic            accept;
  logic [CntW-1:0] tot_len;
  logic [7:0]      src_byte;

  assign accept   = s_valid & s_ready_q;
  assign tot_len  = (wr_cnt_q > MinCnt) ? wr_cnt_q : MinCnt;
  // Positions past the stored length are padding.
  assign src_byte = (rd_idx_q < wr_cnt_q) ? ram_rdata : 8'h00;
  // Single port: write address while collecting, otherwise the prefetch address. Holding
  // rd_idx at 0 through REQ/WAIT leaves byte 0 waiting in ram_rdata before give_data.
  assign ram_addr = (state_q == StCollect) ? wr_cnt_q : rd_idx_q;
  assign ram_we   = (state_q == StCollect) && accept && (wr_cnt_q < MaxCnt);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[AddrW-1:0]] <= s_data;
    end
    if (ram_addr < MaxCnt) begin
      ram_rdata <= mem[ram_addr[AddrW-1:0]];
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_idx_d    = rd_idx_q;
    ph_d        = ph_q;
    cur_d       = cur_q;
    ovf_d       = ovf_q;
    preamble_d  = 1'b0;
    frame_err_d = 1'b0;
    axiov_d     = 1'b0;
    axiod_d     = 2'b00;
    done_d      = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (wr_cnt_q < MaxCnt) begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (s_last) begin
            state_d     = StReq;
            preamble_d  = 1'b1;
            // The last byte itself may be the first one that did not fit.
            frame_err_d = ovf_q | (wr_cnt_q == MaxCnt);
          end
        end
      end

      StReq: begin
        state_d = StWait;
      end

      StWait: begin
        if (give_data) begin
          state_d  = StStream;
          axiov_d  = 1'b1;
          axiod_d  = src_byte[1:0];
          cur_d    = src_byte;
          ph_d     = 2'd1;
          rd_idx_d = rd_idx_q + CntW'(1);
        end
      end

      StStream: begin
        if (ph_q != 2'd0) begin
          axiov_d = 1'b1;
          axiod_d = cur_q[{ph_q, 1'b0} +: 2];
          ph_d    = ph_q + 2'd1;
        end else if (rd_idx_q == tot_len) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          // Next byte was read three cycles ago, so there is no gap between bytes.
          axiov_d  = 1'b1;
          axiod_d  = src_byte[1:0];
          cur_d    = src_byte;
          ph_d     = 2'd1;
          rd_idx_d = rd_idx_q + CntW'(1);
        end
      end

      StDone: begin
        state_d  = StCollect;
        wr_cnt_d = '0;
        rd_idx_d = '0;
        ph_d     = 2'd0;
        ovf_d    = 1'b0;
      end

      default: begin
        state_d = StCollect;
      end
    endcase

    s_ready_d = (state_d == StCollect);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StCollect;
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
      ph_q        <= 2'd0;
      cur_q       <= 8'h00;
      ovf_q       <= 1'b0;
      s_ready_q   <= 1'b1;
      preamble_q  <= 1'b0;
      frame_err_q <= 1'b0;
      axiov_q     <= 1'b0;
      axiod_q     <= 2'b00;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_idx_q    <= rd_idx_d;
      ph_q        <= ph_d;
      cur_q       <= cur_d;
      ovf_q       <= ovf_d;
      s_ready_q   <= s_ready_d;
      preamble_q  <= preamble_d;
      frame_err_q <= frame_err_d;
      axiov_q     <= axiov_d;
      axiod_q     <= axiod_d;
      done_q      <= done_d;
    end
  end

  assign s_ready         = s_ready_q;
  assign preamble_signal = preamble_q;
  assign frame_err       = frame_err_q;
  assign axiov           = axiov_q;
  assign axiod           = axiod_q;
  assign data_complete   = done_q;

endmodule

// File: tb/tb_ether_payload_feeder.sv
module tb_ether_payload_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic       preamble_signal;
  logic       give_data = 1'b0;
  logic       axiov;
  logic [1:0] axiod;
  logic       data_complete;
  logic       frame_err;

  ether_payload_feeder #(
    .MIN_PAYLOAD(46),
    .MAX_PAYLOAD(1500)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .preamble_signal(preamble_signal),
    .give_data      (give_data),
    .axiov          (axiov),
    .axiod          (axiod),
    .data_complete  (data_complete),
    .frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];
  logic [7:0] frm[$];
  bit         mon_en = 1'b0;
  bit         prev_v = 1'b0;
  int         pre_cnt = 0;
  int         err_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every valid dibit is popped and compared against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (preamble_signal) pre_cnt++;
      if (frame_err) err_cnt++;
      if (axiov) begin
        if (exp_q.size() == 0) check("extra_dibit", 1, 0);
        else check("dibit", int'(axiod), int'(exp_q.pop_front()));
      end else begin
        check("axiod_idle", int'(axiod), 0);
        if (prev_v && exp_q.size() != 0) check("axiov_gap", exp_q.size(), 0);
      end
      prev_v = axiov;
    end else begin
      prev_v = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected dibits: stored bytes clamped to 1500, zero-padded to 46, LSB dibit first.
  task automatic push_exp();
    int         n_store;
    int         n_pay;
    logic [7:0] v;
    n_store = (frm.size() > 1500) ? 1500 : frm.size();
    n_pay   = (n_store < 46) ? 46 : n_store;
    for (int b = 0; b < n_pay; b++) begin
      v = (b < n_store) ? frm[b] : 8'h00;
      for (int k = 0; k < 4; k++) exp_q.push_back(v[2*k +: 2]);
    end
  endtask

  task automatic send_frame(input int exp_err);
    tick();
    check("s_ready_collect", int'(s_ready), 1);
    foreach (frm[i]) begin
      s_valid = 1'b1;
      s_data  = frm[i];
      s_last  = (i == frm.size() - 1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    check("preamble", int'(preamble_signal), 1);
    check("frame_err", int'(frame_err), exp_err);
    check("s_ready_busy", int'(s_ready), 0);
    @(negedge clk);
    check("preamble_once", int'(preamble_signal), 0);
    check("frame_err_once", int'(frame_err), 0);
  endtask

  task automatic run_payload(input int n_exp, input bit hold_valid);
    int seen;
    bit got_dc;
    push_exp();
    tick();
    if (hold_valid) begin
      s_valid = 1'b1;
      s_data  = 8'hAA;
      s_last  = 1'b1;
    end
    give_data = 1'b1;
    @(negedge clk);
    check("axiov_before", int'(axiov), 0);
    if (hold_valid) check("s_ready_wait", int'(s_ready), 0);
    tick();
    give_data = 1'b0;
    @(negedge clk);
    check("axiov_first", int'(axiov), 1);
    seen   = 1;
    got_dc = 1'b0;
    for (int c = 0; c < n_exp + 8; c++) begin
      @(negedge clk);
      if (data_complete) begin
        got_dc = 1'b1;
        break;
      end
      if (axiov) seen++;
      if (hold_valid && c == 20) check("s_ready_stream", int'(s_ready), 0);
    end
    if (hold_valid) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    check("data_complete_seen", int'(got_dc), 1);
    check("dibit_count", seen, n_exp);
    check("queue_drained", exp_q.size(), 0);
    check("axiov_at_done", int'(axiov), 0);
    check("axiod_at_done", int'(axiod), 0);
    check("s_ready_at_done", int'(s_ready), 0);
    @(negedge clk);
    check("data_complete_once", int'(data_complete), 0);
    check("s_ready_back", int'(s_ready), 1);
    exp_q.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v_cnt;
    int dc_cnt;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_axiov", int'(axiov), 0);
    check("rst_axiod", int'(axiod), 0);
    check("rst_preamble", int'(preamble_signal), 0);
    check("rst_data_complete", int'(data_complete), 0);
    check("rst_frame_err", int'(frame_err), 0);
    tick();
    rst    = 1'b1;
    mon_en = 1'b1;

    // give_data while collecting is ignored
    tick();
    give_data = 1'b1;
    tick();
    give_data = 1'b0;
    v_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (axiov) v_cnt++;
    end
    check("give_data_in_collect", v_cnt, 0);

    // 3-byte frame, s_valid held high through WAIT/STREAM
    frm = '{8'h01, 8'h02, 8'h03};
    send_frame(0);
    run_payload(184, 1'b1);

    // 46-byte incrementing frame, no padding
    frm.delete();
    for (int i = 0; i < 46; i++) frm.push_back(8'(i));
    send_frame(0);
    run_payload(184, 1'b0);

    // 1500-byte frame, largest that fits
    frm.delete();
    for (int i = 0; i < 1500; i++) frm.push_back(8'(i * 7 + 3));
    send_frame(0);
    run_payload(6000, 1'b0);

    // 1502-byte frame, truncated to 1500
    frm.delete();
    for (int i = 0; i < 1502; i++) frm.push_back(8'(i ^ 8'h5A));
    send_frame(1);
    run_payload(6000, 1'b0);

    // Reset midway through STREAM
    frm = '{8'h11, 8'h22};
    send_frame(0);
    push_exp();
    tick();
    give_data = 1'b1;
    tick();
    give_data = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_stream_axiov", int'(axiov), 0);
    check("rst_stream_s_ready", int'(s_ready), 1);
    check("rst_stream_dc", int'(data_complete), 0);
    dc_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (data_complete) dc_cnt++;
    end
    check("rst_no_data_complete", dc_cnt, 0);
    mon_en = 1'b1;

    // 1-byte frame 0xFF after the reset
    frm = '{8'hFF};
    send_frame(0);
    run_payload(184, 1'b0);

    repeat (4) @(negedge clk);
    check("preamble_total", pre_cnt, 6);
    check("frame_err_total", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ether_payload_feeder.md
# ether_payload_feeder

Store-and-forward payload source that sits directly upstream of the RMII transmit framer. It buffers one frame of bytes from the application and requests a frame with `preamble_signal`. When the framer answers with `give_data`, it streams the payload as a contiguous run of RMII dibits and zero-pads it to the Ethernet minimum. It closes the data phase with a single-cycle `data_complete` pulse.

## Interface

Parameters:
- `MIN_PAYLOAD`, 46: minimum payload bytes; shorter frames are zero-padded to this length.
- `MAX_PAYLOAD`, 1500: maximum stored payload bytes; also sets the buffer depth.

Ports:
- `clk`  in  1  the only clock; all logic is on its rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `s_valid`  in  1  the application byte is valid.
- `s_data`  in  8  the application byte.
- `s_last`  in  1  marks the final byte of the frame.
- `s_ready`  out  1  the block can accept a byte; a transfer occurs when `s_valid & s_ready`.
- `preamble_signal`  out  1  single-cycle pulse requesting frame transmission.
- `give_data`  in  1  single-cycle pulse from the framer: the header is done, start the payload.
- `axiov`  out  1  the payload dibit is valid.
- `axiod`  out  2  the payload dibit.
- `data_complete`  out  1  single-cycle pulse on the cycle after the last payload dibit.
- `frame_err`  out  1  single-cycle pulse: the frame exceeded `MAX_PAYLOAD` and was truncated.

## Operation

- Buffer: single-port byte RAM of depth `MAX_PAYLOAD`, an 11-bit write count `wr_cnt` and an 11-bit read index `rd_idx`. One frame is held at a time.
- States:
  - COLLECT: `s_ready`=1. Each accepted byte is written at `wr_cnt` while `wr_cnt` < `MAX_PAYLOAD`, then `wr_cnt` increments. Once `wr_cnt` == `MAX_PAYLOAD`, further bytes are accepted but discarded and an overflow flag is set. Accepting a byte with `s_last`=1 goes to REQ.
  - REQ: one cycle. Pulse `preamble_signal`, set `frame_err` if the overflow flag is set, then go to WAIT.
  - WAIT: `s_ready`=0. `give_data`=1 goes to STREAM with `rd_idx`=0 and dibit index 0.
  - STREAM: one dibit per cycle, no gaps. Byte `b` is sent LSB-first: `b[1:0]`, `b[3:2]`, `b[5:4]`, `b[7:6]`. Byte positions < `wr_cnt` come from RAM; positions from `wr_cnt` to `MIN_PAYLOAD`-1 send 0. After the last dibit of byte max(`wr_cnt`, `MIN_PAYLOAD`)-1, go to DONE.
  - DONE: one cycle. Pulse `data_complete`, clear `wr_cnt` and the flags, go to COLLECT.
- RAM read latency is hidden by prefetch, so `axiov` never drops mid-frame.
- Total dibits per frame = 4·max(stored length, `MIN_PAYLOAD`). Stored length is clamped to `MAX_PAYLOAD`.
- A frame always holds at least 1 byte, because every beat carries a byte.
- `give_data` outside WAIT is ignored.
- `s_valid` while `s_ready`=0 is ignored; upstream holds the byte.

## Timing

- Reset (`rst`=0 at an edge): state=COLLECT, `wr_cnt`=0, `s_ready`=1. `axiov`, `axiod`, `preamble_signal`, `data_complete` and `frame_err` are all 0. Any frame in progress is discarded at any state.
- All outputs are registered.
- Last-byte handshake at cycle T:
  - `preamble_signal`=1 at T+1 only.
  - `frame_err`, if set, pulses at T+1.
  - `s_ready`=0 from T+1.
- `give_data` high at cycle G: the first `axiov`=1 is at G+1. `axiov` stays high for exactly N = 4·max(len, `MIN_PAYLOAD`) consecutive cycles, G+1 .. G+N.
- `data_complete`=1 at G+N+1 only. `axiov`=0 and `axiod`=0 from G+N+1.
- `s_ready`=1 again at G+N+2.
- `axiod` is 0 whenever `axiov`=0.
- Reset asserted during STREAM: `axiov` is 0 at the next cycle and no `data_complete` is emitted.

## Test plan

- 3-byte frame 0x01, 0x02, 0x03, then `give_data`: 184 contiguous dibits starting 1,0,0,0, 2,0,0,0, 3,0,0,0, followed by 172 zero dibits. `data_complete` one cycle after the last dibit.
- 46-byte incrementing frame 0x00..0x2D: exactly 184 dibits, no padding. The last byte 0x2D gives dibits 1,3,2,0.
- 1500-byte frame: 6000 contiguous dibits; `frame_err` stays 0; no gap in `axiov` across RAM prefetch boundaries.
- 1502-byte frame: `frame_err` pulses once, on the cycle `preamble_signal` pulses. Exactly 6000 dibits carrying only the first 1500 bytes.
- Protocol misuse: `give_data` pulsed during COLLECT is ignored, with no `axiov`. `s_valid` held during WAIT/STREAM is not accepted (`s_ready`=0). A second frame submitted after `data_complete` is transmitted correctly.
- `rst` driven low for 1 cycle midway through STREAM: next cycle `axiov`=0, `s_ready`=1, no `data_complete`. A following 1-byte frame 0xFF gives 184 dibits starting 3,3,3,3.
